// File: rtl/seq_serializer_if.sv
// Parallel-in / serial-out handshake bundle for seq_serializer.
// master drives words in; slave (the serializer) drives the bit stream out.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_end;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  frame_end,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output frame_end,
    output busy
  );
endinterface

// File: rtl/seq_serializer.sv
// Word serializer: one-word holding register feeding a WIDTH-bit shifter.
// Back-to-back words stream with no gap; all outputs come from registers.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seq_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_adv;
  logic             w_bit;

  // Hold moves to the shifter when the shifter is empty or on its last bit;
  // on that edge din_ready is already 0, so hold cannot refill at once.
  assign w_last   = (r_cnt == LAST);
  assign w_load   = r_hold_full && ((r_state == IDLE) || w_last);
  assign w_accept = bus.din_valid && !r_hold_full;
  assign w_adv    = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                              : {1'b0, r_shift[WIDTH-1:1]};
  assign w_bit    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next state: stay in SHIFT while words keep arriving in hold
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (r_hold_full) w_next = SHIFT;
      SHIFT: if (w_last && !r_hold_full) w_next = IDLE;
    endcase
  end

  // Holding register, shifter and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) r_hold <= bus.din;
      if (w_load)        r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;
      if (w_load) begin
        r_shift <= r_hold;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        if (w_last) begin
          r_shift <= '0;
          r_cnt   <= '0;
        end else begin
          r_shift <= w_adv;
          r_cnt   <= r_cnt + CW'(1);
        end
      end
    end
  end

  // FSM outputs decoded from registered state only
  always_comb begin
    bus.din_ready  = !r_hold_full;
    bus.sout_valid = (r_state == SHIFT);
    bus.sout       = (r_state == SHIFT) && w_bit;
    bus.frame_end  = (r_state == SHIFT) && w_last;
    bus.busy       = (r_state == SHIFT) || r_hold_full;
  end
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: MSB-first and LSB-first instances.
// Hand-computed bit streams, backpressure and async reset cases.
module tb_seq_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  seq_serializer_if #(.WIDTH(8)) if0 ();
  seq_serializer_if #(.WIDTH(8)) if1 ();

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic       bits[$];
  int         first_i, last_i, fe_cnt, acc_cnt, stall_cnt, pulses, nv;
  logic [3:0] hist;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bits.delete();
    first_i = -1; last_i = -1;
    fe_cnt = 0; acc_cnt = 0; stall_cnt = 0;
    pulses = 0; nv = 0; hist = '0;
  endtask

  task automatic sample(input int c);
    if (if0.sout_valid === 1'b1) begin
      bits.push_back(if0.sout);
      if (first_i < 0) first_i = c;
      last_i = c;
      hist = {hist[2:0], if0.sout};
      nv++;
      if (nv >= 4 && hist == 4'b1101) pulses++;
    end
    if (if0.frame_end === 1'b1) fe_cnt++;
  endtask

  task automatic run(input int cyc);
    logic v, r;
    for (int c = 0; c < cyc; c++) begin
      v = (q.size() != 0);
      if0.din_valid = v;
      if0.din = v ? q[0] : 8'h00;
      r = if0.din_ready;
      if (v && !r) stall_cnt++;
      tick();
      if (v && r) begin
        void'(q.pop_front());
        acc_cnt++;
      end
      sample(c);
    end
    if0.din_valid = 1'b0;
  endtask

  function automatic logic [31:0] packed_bits();
    logic [31:0] p = '0;
    foreach (bits[i]) p = {p[30:0], bits[i]};
    return p;
  endfunction

  logic [7:0] exp_w;

  initial begin
    if0.din = '0; if0.din_valid = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0;
    #2;
    chk("rst_ready", if0.din_ready, 1);
    chk("rst_sout", if0.sout, 0);
    chk("rst_svalid", if0.sout_valid, 0);
    chk("rst_fend", if0.frame_end, 0);
    chk("rst_busy", if0.busy, 0);
    tick(); tick();
    rst = 1'b0;

    // idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_svalid", if0.sout_valid, 0);
      chk("idle_sout", if0.sout, 0);
      chk("idle_busy", if0.busy, 0);
    end

    // single word D0, cycle by cycle
    clr();
    if0.din = 8'hD0; if0.din_valid = 1'b1;
    tick();
    if0.din_valid = 1'b0;
    chk("d0_acc_ready", if0.din_ready, 0);
    chk("d0_acc_busy", if0.busy, 1);
    chk("d0_acc_svalid", if0.sout_valid, 0);
    exp_w = 8'b1101_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample(i);
      chk("d0_svalid", if0.sout_valid, 1);
      chk("d0_bit", if0.sout, exp_w[7-i]);
      chk("d0_fend", if0.frame_end, (i == 7) ? 1 : 0);
    end
    tick();
    chk("d0_done_svalid", if0.sout_valid, 0);
    chk("d0_done_busy", if0.busy, 0);
    chk("d0_pulses", pulses, 1);

    // back-to-back DD, B6
    clr();
    q.push_back(8'hDD); q.push_back(8'hB6);
    run(24);
    chk("b2b_len", bits.size(), 16);
    chk("b2b_bits", packed_bits(), 32'h0000_DDB6);
    chk("b2b_gap", last_i - first_i + 1 - bits.size(), 0);
    chk("b2b_fend", fe_cnt, 2);
    chk("b2b_acc", acc_cnt, 2);

    // backpressure: third word waits for hold to drain
    clr();
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56);
    run(40);
    chk("bp_acc", acc_cnt, 3);
    chk("bp_stalled", (stall_cnt > 0) ? 1 : 0, 1);
    chk("bp_len", bits.size(), 24);
    chk("bp_bits", packed_bits(), 32'h0012_3456);
    chk("bp_gap", last_i - first_i + 1 - bits.size(), 0);
    chk("bp_fend", fe_cnt, 3);

    // LSB-first instance with 0B
    if1.din = 8'h0B; if1.din_valid = 1'b1;
    tick();
    if1.din_valid = 1'b0;
    tick();
    exp_w = 8'b1101_0000;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_svalid", if1.sout_valid, 1);
      chk("lsb_bit", if1.sout, exp_w[7-i]);
      tick();
    end
    chk("lsb_done", if1.sout_valid, 0);

    // async reset during bit 4 of FF with hold full
    if0.din = 8'hFF; if0.din_valid = 1'b1;
    tick();
    tick();
    tick();
    if0.din_valid = 1'b0;
    tick();
    tick();
    chk("ar_pre_ready", if0.din_ready, 0);
    chk("ar_pre_sout", if0.sout, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_sout", if0.sout, 0);
    chk("ar_svalid", if0.sout_valid, 0);
    chk("ar_fend", if0.frame_end, 0);
    chk("ar_busy", if0.busy, 0);
    chk("ar_ready", if0.din_ready, 1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_post_svalid", if0.sout_valid, 0);
      chk("ar_post_busy", if0.busy, 0);
    end
    clr();
    q.push_back(8'hA5);
    run(14);
    chk("ar_a5_len", bits.size(), 8);
    chk("ar_a5_bits", packed_bits(), 32'h0000_00A5);
    chk("ar_a5_fend", fe_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
